// File: rtl/fsm_msi_cpu_requests_controller.sv
// CPU-side MSI controller for one direct-mapped cache block: classifies processor
// requests as hits or misses and sequences the bus transactions that a miss needs.
module fsm_msi_cpu_requests_controller #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_write,
  input  logic [TAG_W-1:0]  cpu_tag,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic              bus_read_miss,
  output logic              bus_write_miss,
  output logic              bus_invalidate,
  output logic              bus_write_back,
  output logic [TAG_W-1:0]  bus_tag,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              snoop_update,
  input  logic [1:0]        snoop_state_next,
  output logic [1:0]        state_out
);

  localparam logic [1:0] ST_INVALID  = 2'b00;
  localparam logic [1:0] ST_MODIFIED = 2'b01;
  localparam logic [1:0] ST_SHARED   = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARB  = 3'd1,
    WB   = 3'd2,
    MISS = 3'd3,
    DONE = 3'd4
  } fsm_t;

  fsm_t              fsm_r;
  logic [TAG_W-1:0]  tag_r;
  logic [DATA_W-1:0] data_r;
  logic              hit_s;
  logic              fast_hit_s;
  logic              shared_write_hit_s;
  logic              dirty_victim_s;

  // An encoding the bus side should never send collapses to INVALID.
  function automatic logic [1:0] sanitize_state(input logic [1:0] s);
    logic [1:0] r;
    case (s)
      ST_INVALID, ST_MODIFIED, ST_SHARED: r = s;
      default:                            r = ST_INVALID;
    endcase
    return r;
  endfunction

  // Classify the pending request against the stored block.
  always_comb begin
    hit_s              = (state_out != ST_INVALID) && (tag_r == cpu_tag);
    fast_hit_s         = hit_s && (!cpu_write || (state_out == ST_MODIFIED));
    shared_write_hit_s = hit_s && cpu_write && (state_out == ST_SHARED);
    dirty_victim_s     = !hit_s && (state_out == ST_MODIFIED);
  end

  // Controller FSM; every output is a register updated here.
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_r          <= IDLE;
      tag_r          <= '0;
      data_r         <= '0;
      state_out      <= ST_INVALID;
      cpu_ready      <= 1'b0;
      cpu_rdata      <= '0;
      bus_req        <= 1'b0;
      bus_read_miss  <= 1'b0;
      bus_write_miss <= 1'b0;
      bus_invalidate <= 1'b0;
      bus_write_back <= 1'b0;
      bus_tag        <= '0;
      bus_wdata      <= '0;
    end else begin
      case (fsm_r)
        IDLE: begin
          if (snoop_update) begin
            state_out <= sanitize_state(snoop_state_next);
          end else if (cpu_req) begin
            if (fast_hit_s) begin
              if (cpu_write) begin
                data_r <= cpu_wdata;
              end
              cpu_rdata <= cpu_write ? cpu_wdata : data_r;
              cpu_ready <= 1'b1;
              fsm_r     <= DONE;
            end else begin
              bus_req <= 1'b1;
              fsm_r   <= ARB;
            end
          end
        end

        ARB: begin
          // A snoop always beats a same-cycle grant; the request is reclassified in IDLE.
          if (snoop_update) begin
            state_out <= sanitize_state(snoop_state_next);
            bus_req   <= 1'b0;
            fsm_r     <= IDLE;
          end else if (bus_grant) begin
            if (shared_write_hit_s) begin
              bus_invalidate <= 1'b1;
              bus_tag        <= tag_r;
              state_out      <= ST_MODIFIED;
              data_r         <= cpu_wdata;
              cpu_rdata      <= cpu_wdata;
              cpu_ready      <= 1'b1;
              bus_req        <= 1'b0;
              fsm_r          <= DONE;
            end else if (dirty_victim_s) begin
              bus_write_back <= 1'b1;
              bus_tag        <= tag_r;
              bus_wdata      <= data_r;
              fsm_r          <= WB;
            end else begin
              bus_read_miss  <= !cpu_write;
              bus_write_miss <= cpu_write;
              bus_tag        <= cpu_tag;
              fsm_r          <= MISS;
            end
          end
        end

        WB: begin
          if (mem_ready) begin
            state_out      <= ST_INVALID;
            bus_write_back <= 1'b0;
            bus_wdata      <= '0;
            bus_read_miss  <= !cpu_write;
            bus_write_miss <= cpu_write;
            bus_tag        <= cpu_tag;
            fsm_r          <= MISS;
          end
        end

        MISS: begin
          if (mem_ready) begin
            tag_r <= cpu_tag;
            if (cpu_write) begin
              data_r    <= cpu_wdata;
              cpu_rdata <= cpu_wdata;
              state_out <= ST_MODIFIED;
            end else begin
              data_r    <= mem_rdata;
              cpu_rdata <= mem_rdata;
              state_out <= ST_SHARED;
            end
            bus_read_miss  <= 1'b0;
            bus_write_miss <= 1'b0;
            bus_req        <= 1'b0;
            cpu_ready      <= 1'b1;
            fsm_r          <= DONE;
          end
        end

        DONE: begin
          cpu_ready      <= 1'b0;
          cpu_rdata      <= '0;
          bus_invalidate <= 1'b0;
          fsm_r          <= IDLE;
        end

        default: begin
          cpu_ready      <= 1'b0;
          bus_req        <= 1'b0;
          bus_read_miss  <= 1'b0;
          bus_write_miss <= 1'b0;
          bus_invalidate <= 1'b0;
          bus_write_back <= 1'b0;
          fsm_r          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_msi_cpu_requests_controller.sv
// Randomized scoreboard bench: a block-level MSI model predicts bus commands and
// completions; a monitor pops and compares them as the controller presents them.
module tb_fsm_msi_cpu_requests_controller;

  localparam logic [1:0] INV = 2'b00;
  localparam logic [1:0] MOD = 2'b01;
  localparam logic [1:0] SHR = 2'b10;
  localparam int K_READY = 0, K_INV = 1, K_WB = 2, K_RM = 3, K_WM = 4;

  logic       clock = 1'b0, reset = 1'b1;
  logic       cpu_req = 1'b0, cpu_write = 1'b0;
  logic [3:0] cpu_tag = 4'd0;
  logic [7:0] cpu_wdata = 8'd0;
  logic       cpu_ready;
  logic [7:0] cpu_rdata;
  logic       bus_req, bus_grant = 1'b0;
  logic       bus_read_miss, bus_write_miss, bus_invalidate, bus_write_back;
  logic [3:0] bus_tag;
  logic [7:0] bus_wdata;
  logic       mem_ready = 1'b0;
  logic [7:0] mem_rdata = 8'd0;
  logic       snoop_update = 1'b0;
  logic [1:0] snoop_state_next = 2'b00;
  logic [1:0] state_out;

  fsm_msi_cpu_requests_controller #(.TAG_W(4), .DATA_W(8)) dut (
    .clock(clock), .reset(reset), .cpu_req(cpu_req), .cpu_write(cpu_write),
    .cpu_tag(cpu_tag), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .bus_req(bus_req), .bus_grant(bus_grant), .bus_read_miss(bus_read_miss),
    .bus_write_miss(bus_write_miss), .bus_invalidate(bus_invalidate),
    .bus_write_back(bus_write_back), .bus_tag(bus_tag), .bus_wdata(bus_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .snoop_update(snoop_update),
    .snoop_state_next(snoop_state_next), .state_out(state_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         kind;
    logic [3:0] tag;
    logic [7:0] data;
    logic [1:0] st;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0, failures = 0;
  logic [1:0] m_state = INV;
  logic [3:0] m_tag = 4'd0;
  logic [7:0] m_data = 8'd0;
  logic [7:0] fill_data = 8'd0;
  bit         hold_mem = 1'b0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_eq(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input int kind, input logic [3:0] tg, input logic [7:0] dt, input logic [1:0] st);
    exp_t e;
    e.kind = kind; e.tag = tg; e.data = dt; e.st = st;
    exp_q.push_back(e);
  endtask

  function automatic logic [1:0] rand_state();
    case ($urandom_range(0, 2))
      0:       return INV;
      1:       return MOD;
      default: return SHR;
    endcase
  endfunction

  // Model outcome of a granted request: upgrade, or (write-back) + fill.
  task automatic model_grant(input bit wr, input logic [3:0] tg, input logic [7:0] wd, input logic [7:0] fd);
    if (wr && m_state == SHR && m_tag == tg) begin
      push(K_INV, m_tag, 8'd0, 2'b00);
      m_state = MOD;
      m_data  = wd;
    end else begin
      if (m_state == MOD) push(K_WB, m_tag, m_data, 2'b00);
      push(wr ? K_WM : K_RM, tg, 8'd0, 2'b00);
      m_tag   = tg;
      m_data  = wr ? wd : fd;
      m_state = wr ? MOD : SHR;
    end
    push(K_READY, 4'd0, m_data, m_state);
  endtask

  task automatic sb_pop(input int kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_unexpected", kind, -1);
    end else begin
      e = exp_q.pop_front();
      check_eq("sb_kind", kind, e.kind);
      if (kind == K_READY) begin
        check_eq("ready_rdata", int'(cpu_rdata), int'(e.data));
        check_eq("ready_state", int'(state_out), int'(e.st));
      end else begin
        check_eq("cmd_tag", int'(bus_tag), int'(e.tag));
        if (kind == K_WB) check_eq("wb_data", int'(bus_wdata), int'(e.data));
      end
    end
  endtask

  // Monitor: compares each new command / completion against the scoreboard.
  logic p_inv = 1'b0, p_wb = 1'b0, p_rm = 1'b0, p_wm = 1'b0;
  int   n_cmd;
  always @(negedge clock) begin
    if (!reset) begin
      n_cmd = int'(bus_invalidate) + int'(bus_write_back) + int'(bus_read_miss) + int'(bus_write_miss);
      if (n_cmd > 0) check_eq("single_command", n_cmd, 1);
      if (bus_invalidate) check_eq("invalidate_width", int'(p_inv), 0);
      if (bus_write_back || bus_read_miss || bus_write_miss) check_eq("bus_req_held", int'(bus_req), 1);
      if (bus_invalidate && !p_inv) sb_pop(K_INV);
      if (bus_write_back && !p_wb) sb_pop(K_WB);
      if (bus_read_miss && !p_rm) sb_pop(K_RM);
      if (bus_write_miss && !p_wm) sb_pop(K_WM);
      if (cpu_ready) sb_pop(K_READY);
    end
    p_inv <= bus_invalidate;
    p_wb  <= bus_write_back;
    p_rm  <= bus_read_miss;
    p_wm  <= bus_write_miss;
  end

  // Memory responder: random-latency completion strobe for write-backs and fills.
  initial begin
    forever begin
      step();
      if (!reset && (bus_write_back || ((bus_read_miss || bus_write_miss) && !hold_mem))) begin
        repeat ($urandom_range(0, 3)) step();
        mem_ready = 1'b1;
        mem_rdata = bus_write_back ? 8'($urandom) : fill_data;
        step();
        mem_ready = 1'b0;
        mem_rdata = 8'($urandom);
      end
    end
  end

  // arb_snoop: 0 none, 1 random, 2 forced INVALID snoop, 3 forced INVALID snoop with grant.
  task automatic do_req(input bit wr, input logic [3:0] tg, input logic [7:0] wd, input logic [7:0] fd,
                        input int arb_snoop, input bit idle_snoop, input bit b2b, input bit keep_req);
    int lat, exp_lat, snoops, guard;
    bit done, force_snoop;
    logic [1:0] sn;
    cpu_req = 1'b1; cpu_write = wr; cpu_tag = tg; cpu_wdata = wd; fill_data = fd;
    exp_lat = b2b ? 2 : 1;
    if (idle_snoop && !b2b) begin
      sn = rand_state();
      snoop_update = 1'b1; snoop_state_next = sn; m_state = sn;
      step();
      snoop_update = 1'b0;
    end
    done = 1'b0; snoops = 0; guard = 0;
    while (!done && guard < 6) begin
      guard++;
      if (m_state != INV && m_tag == tg && (!wr || m_state == MOD)) begin
        if (wr) m_data = wd;
        push(K_READY, 4'd0, m_data, m_state);
        lat = 0;
        do begin
          step(); lat++;
          check_eq("hit_no_bus_req", int'(bus_req), 0);
        end while (!cpu_ready && lat < 4);
        check_eq("hit_latency", lat, exp_lat);
        done = 1'b1;
      end else begin
        lat = 0;
        do begin step(); lat++; end while (!bus_req && lat < 4);
        check_eq("arb_latency", lat, exp_lat);
        exp_lat = 1;
        force_snoop = (arb_snoop >= 2 && snoops == 0) ||
                      (arb_snoop == 1 && snoops < 2 && $urandom_range(0, 3) == 0);
        if (!bus_req) begin
          done = 1'b1;
        end else if (force_snoop) begin
          sn = (arb_snoop >= 2) ? INV : rand_state();
          snoops++;
          snoop_update = 1'b1; snoop_state_next = sn; m_state = sn;
          bus_grant = (arb_snoop == 3) ? 1'b1 : ((arb_snoop == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
          step();
          snoop_update = 1'b0; bus_grant = 1'b0;
          check_eq("snoop_releases_bus", int'(bus_req), 0);
        end else begin
          repeat ($urandom_range(0, 2)) step();
          model_grant(wr, tg, wd, fd);
          bus_grant = 1'b1;
          lat = 0;
          do begin step(); lat++; end while (!cpu_ready && lat < 40);
          check_eq("completion", int'(cpu_ready), 1);
          bus_grant = 1'b0;
          done = 1'b1;
        end
      end
    end
    if (!keep_req) begin
      cpu_req = 1'b0;
      step();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] tg;
    repeat (3) step();
    check_eq("reset_state", int'(state_out), int'(INV));
    check_eq("reset_ready", int'(cpu_ready), 0);
    check_eq("reset_bus_req", int'(bus_req), 0);
    check_eq("reset_cmds", int'({bus_read_miss, bus_write_miss, bus_invalidate, bus_write_back}), 0);
    check_eq("reset_tag_data", int'({bus_tag, bus_wdata, cpu_rdata}), 0);
    reset = 1'b0;
    step();

    do_req(1'b0, 4'd3, 8'h00, 8'hA5, 0, 1'b0, 1'b0, 1'b0); // read miss
    do_req(1'b1, 4'd3, 8'h5A, 8'h00, 0, 1'b0, 1'b0, 1'b0); // write hit SHARED -> invalidate
    do_req(1'b0, 4'd3, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b0); // read hit 0x5A
    do_req(1'b0, 4'd7, 8'h00, 8'h3C, 0, 1'b0, 1'b0, 1'b0); // dirty victim
    do_req(1'b0, 4'd3, 8'h00, 8'h11, 0, 1'b0, 1'b0, 1'b0); // SHARED tag 3
    do_req(1'b1, 4'd3, 8'h77, 8'h00, 2, 1'b0, 1'b0, 1'b0); // snoop race in ARB
    for (int i = 0; i < 6; i++) begin                      // back-to-back hits
      do_req(1'(i % 2), 4'd3, 8'($urandom), 8'h00, 0, 1'b0, i > 0, i < 5);
    end
    do_req(1'b0, 4'd5, 8'h00, 8'h66, 0, 1'b0, 1'b0, 1'b0);
    do_req(1'b1, 4'd5, 8'h99, 8'h00, 3, 1'b0, 1'b0, 1'b0); // snoop with grant: snoop wins

    repeat (300) begin
      do_req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
             1, $urandom_range(0, 5) == 0, 1'b0, 1'b0);
    end

    // Reset while stalled in MISS.
    hold_mem = 1'b1;
    tg = m_tag + 4'd1;
    if (m_state == MOD) push(K_WB, m_tag, m_data, 2'b00);
    push(K_RM, tg, 8'd0, 2'b00);
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_tag = tg; bus_grant = 1'b1;
    for (int i = 0; i < 40 && !bus_read_miss; i++) step();
    check_eq("reached_miss", int'(bus_read_miss), 1);
    reset = 1'b1;
    step();
    check_eq("midreset_state", int'(state_out), int'(INV));
    check_eq("midreset_bus_req", int'(bus_req), 0);
    check_eq("midreset_cmds", int'({bus_read_miss, bus_write_miss, bus_invalidate, bus_write_back, cpu_ready}), 0);
    reset = 1'b0; cpu_req = 1'b0; bus_grant = 1'b0; hold_mem = 1'b0;
    exp_q.delete();
    m_state = INV; m_tag = 4'd0; m_data = 8'd0;
    step();
    do_req(1'b0, 4'd0, 8'h00, 8'h42, 0, 1'b0, 1'b0, 1'b0); // tag 0 must miss after reset

    repeat (5) step();
    check_eq("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
